// File: rtl/rst_seq_rcv.sv
// Reset sequencer: synchronizes async reset release, stretches it, then frees
// the downstream reset domains one by one; a software request re-runs the sequence.
module rst_seq_rcv #(
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 10,
  parameter int NUM_DOMAINS    = 3,
  parameter int STAGGER_CYCLES = 4,
  parameter int CNT_W          = 16
) (
  input  logic                   clk_tb,
  input  logic                   rst,
  input  logic                   sw_rst_req,
  output logic [NUM_DOMAINS-1:0] rst_dom,
  output logic                   in_reset,
  output logic                   rst_done,
  output logic [CNT_W-1:0]       sw_rst_cnt
);

  localparam int MAX_CYC = (STRETCH_CYCLES > STAGGER_CYCLES) ? STRETCH_CYCLES : STAGGER_CYCLES;
  localparam int TMR_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    ST_ASSERT,
    ST_SYNC,
    ST_STRETCH,
    ST_RELEASE,
    ST_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   done_q, done_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_DOMAINS-1:0] dom_shift;
  logic                   last_rel;
  logic                   do_release;

  always_ff @(posedge clk_tb or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Shifting left clears the lowest still-held bit, keeping the pattern thermometer-ordered.
  assign dom_shift = dom_q << 1;
  assign last_rel  = (dom_shift == '0);

  always_ff @(posedge clk_tb or posedge rst) begin
    if (rst) begin
      state_q <= ST_ASSERT;
      tmr_q   <= '0;
      dom_q   <= '1;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      dom_q   <= dom_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    dom_d      = dom_q;
    done_d     = 1'b0;
    cnt_d      = cnt_q;
    do_release = 1'b0;
    case (state_q)
      ST_ASSERT: state_d = ST_SYNC;
      ST_SYNC: begin
        // The edge that first sees the chain output already counts as stretch cycle 1.
        if (sync_q[SYNC_STAGES-1]) begin
          if (STRETCH_CYCLES == 1) begin
            do_release = 1'b1;
          end else begin
            state_d = ST_STRETCH;
            tmr_d   = TMR_W'(1);
          end
        end
      end
      ST_STRETCH: begin
        if (tmr_q == TMR_W'(STRETCH_CYCLES - 1)) do_release = 1'b1;
        else                                     tmr_d = tmr_q + TMR_W'(1);
      end
      ST_RELEASE: begin
        if (tmr_q == TMR_W'(STAGGER_CYCLES - 1)) do_release = 1'b1;
        else                                     tmr_d = tmr_q + TMR_W'(1);
      end
      ST_DONE: begin
        if (sw_rst_req) begin
          state_d = ST_STRETCH;
          tmr_d   = '0;
          dom_d   = '1;
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_ASSERT;
    endcase

    if (do_release) begin
      dom_d = dom_shift;
      tmr_d = '0;
      if (last_rel) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_RELEASE;
      end
    end
  end

  assign rst_dom    = dom_q;
  assign in_reset   = |dom_q;
  assign rst_done   = done_q;
  assign sw_rst_cnt = cnt_q;

endmodule

// File: tb/tb_rst_seq_rcv.sv
// Bench for rst_seq_rcv: randomized reset/request scenarios checked against a
// release-time model (edge index -> expected domain pattern, done pulse, count).
module tb_rst_seq_rcv;

  localparam int SYNC    = 2;
  localparam int STRETCH = 10;
  localparam int NDOM    = 3;
  localparam int STAG    = 4;
  localparam int CW      = 2;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam int PO_FIRST = SYNC + STRETCH;
  localparam int SW_FIRST = STRETCH;
  localparam int STEADY   = 1000;
  localparam logic [NDOM+CW+1:0] RST_VEC = {{NDOM{1'b1}}, 1'b1, 1'b0, {CW{1'b0}}};

  logic            clk_tb;
  logic            rst;
  logic            sw_rst_req;
  logic [NDOM-1:0] rst_dom;
  logic            in_reset;
  logic            rst_done;
  logic [CW-1:0]   sw_rst_cnt;
  logic [NDOM+CW+1:0] obs;
  logic [NDOM+CW+1:0] exp_v;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_cnt   = 0;

  rst_seq_rcv #(
    .SYNC_STAGES   (SYNC),
    .STRETCH_CYCLES(STRETCH),
    .NUM_DOMAINS   (NDOM),
    .STAGGER_CYCLES(STAG),
    .CNT_W         (CW)
  ) dut (
    .clk_tb    (clk_tb),
    .rst       (rst),
    .sw_rst_req(sw_rst_req),
    .rst_dom   (rst_dom),
    .in_reset  (in_reset),
    .rst_done  (rst_done),
    .sw_rst_cnt(sw_rst_cnt)
  );

  assign obs = {rst_dom, in_reset, rst_done, sw_rst_cnt};

  // clock / reset block
  initial begin
    clk_tb = 1'b0;
    forever #5 clk_tb = ~clk_tb;
  end

  // Expected outputs j edges after an anchor; domain k is free from edge first + k*STAG on.
  function automatic logic [NDOM+CW+1:0] model(int j, int first, int cnt);
    logic [NDOM-1:0] d;
    logic            busy;
    logic            done;
    d = '1;
    for (int k = 0; k < NDOM; k++) begin
      if (j >= first + k * STAG) d[k] = 1'b0;
    end
    busy = 1'b0;
    for (int k = 0; k < NDOM; k++) begin
      if (j < first + k * STAG) busy = 1'b1;
    end
    done = (j == first + (NDOM - 1) * STAG);
    return {d, busy, done, CW'(cnt)};
  endfunction

  function automatic int sat_inc(int c);
    return (c < CNT_MAX) ? c + 1 : CNT_MAX;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk_tb);
    #1;
  endtask

  task automatic apply_rst();
    rst        = 1'b1;
    sw_rst_req = 1'b0;
    repeat (3) tick();
    rst     = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    #2;
    total_cnt++;
    if (obs !== RST_VEC) $display("FAIL reset_initial got %b exp %b", obs, RST_VEC);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if (obs !== RST_VEC) $display("FAIL reset_held cyc=%0d got %b exp %b", i, obs, RST_VEC);
      else pass_cnt++;
    end
    rst = 1'b0;
  endtask

  task automatic test_power_on();
    for (int j = 1; j <= 29; j++) begin
      tick();
      exp_v = model(j, PO_FIRST, exp_cnt);
      total_cnt++;
      if (obs !== exp_v) $display("FAIL power_on E%0d got %b exp %b", j, obs, exp_v);
      else pass_cnt++;
    end
  endtask

  task automatic test_sw_reset();
    int gap;
    gap = $urandom_range(0, 3);
    for (int i = 0; i < gap; i++) begin
      tick();
      exp_v = model(STEADY, SW_FIRST, exp_cnt);
      total_cnt++;
      if (obs !== exp_v) $display("FAIL sw_idle i=%0d got %b exp %b", i, obs, exp_v);
      else pass_cnt++;
    end
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    exp_cnt = sat_inc(exp_cnt);
    for (int j = 0; j <= 20; j++) begin
      if (j > 0) tick();
      exp_v = model(j, SW_FIRST, exp_cnt);
      total_cnt++;
      if (obs !== exp_v) $display("FAIL sw_reset j=%0d got %b exp %b", j, obs, exp_v);
      else pass_cnt++;
    end
  endtask

  task automatic test_ignored();
    int p;
    rst = 1'b1;
    #2;
    total_cnt++;
    if (obs !== RST_VEC) $display("FAIL ignored_async_rst got %b exp %b", obs, RST_VEC);
    else pass_cnt++;
    repeat (2) tick();
    rst     = 1'b0;
    exp_cnt = 0;
    p = $urandom_range(1, 20);
    for (int j = 1; j <= 24; j++) begin
      sw_rst_req = (j == p);
      tick();
      exp_v = model(j, PO_FIRST, exp_cnt);
      total_cnt++;
      if (obs !== exp_v) $display("FAIL ignored p=%0d E%0d got %b exp %b", p, j, obs, exp_v);
      else pass_cnt++;
    end
    sw_rst_req = 1'b0;
  endtask

  task automatic test_async_abort();
    int a;
    apply_rst();
    a = $urandom_range(17, 26);
    for (int j = 1; j <= a; j++) begin
      tick();
      exp_v = model(j, PO_FIRST, exp_cnt);
      total_cnt++;
      if (obs !== exp_v) $display("FAIL abort_pre E%0d got %b exp %b", j, obs, exp_v);
      else pass_cnt++;
    end
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if (obs !== RST_VEC) $display("FAIL abort_glitch a=%0d got %b exp %b", a, obs, RST_VEC);
    else pass_cnt++;
    #2 rst = 1'b0;
    exp_cnt = 0;
    for (int j = 1; j <= 22; j++) begin
      tick();
      exp_v = model(j, PO_FIRST, exp_cnt);
      total_cnt++;
      if (obs !== exp_v) $display("FAIL abort_post E%0d got %b exp %b", j, obs, exp_v);
      else pass_cnt++;
    end
  endtask

  task automatic test_saturation();
    int gap;
    int p;
    for (int r = 0; r < 5; r++) begin
      gap = $urandom_range(0, 3);
      for (int i = 0; i < gap; i++) begin
        tick();
        exp_v = model(STEADY, SW_FIRST, exp_cnt);
        total_cnt++;
        if (obs !== exp_v) $display("FAIL sat_idle r=%0d got %b exp %b", r, obs, exp_v);
        else pass_cnt++;
      end
      sw_rst_req = 1'b1;
      tick();
      sw_rst_req = 1'b0;
      exp_cnt = sat_inc(exp_cnt);
      exp_v = model(0, SW_FIRST, exp_cnt);
      total_cnt++;
      if (obs !== exp_v) $display("FAIL sat_accept r=%0d got %b exp %b", r, obs, exp_v);
      else pass_cnt++;
      p = $urandom_range(1, 18);
      for (int j = 1; j <= 18; j++) begin
        sw_rst_req = (j == p);
        tick();
        exp_v = model(j, SW_FIRST, exp_cnt);
        total_cnt++;
        if (obs !== exp_v) $display("FAIL sat_seq r=%0d j=%0d got %b exp %b", r, j, obs, exp_v);
        else pass_cnt++;
      end
      sw_rst_req = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    apply_rst();
    for (int j = 1; j <= 20; j++) begin
      tick();
      exp_v = model(j, PO_FIRST, exp_cnt);
      total_cnt++;
      if (obs !== exp_v) $display("FAIL b2b_power_on E%0d got %b exp %b", j, obs, exp_v);
      else pass_cnt++;
    end
    sw_rst_req = 1'b1;
    for (int s = 0; s < 2; s++) begin
      tick();
      exp_cnt = sat_inc(exp_cnt);
      for (int j = 0; j <= 18; j++) begin
        if (j > 0) tick();
        exp_v = model(j, SW_FIRST, exp_cnt);
        total_cnt++;
        if (obs !== exp_v) $display("FAIL b2b s=%0d j=%0d got %b exp %b", s, j, obs, exp_v);
        else pass_cnt++;
      end
    end
    sw_rst_req = 1'b0;
    for (int j = 19; j <= 20; j++) begin
      tick();
      exp_v = model(j, SW_FIRST, exp_cnt);
      total_cnt++;
      if (obs !== exp_v) $display("FAIL b2b_tail j=%0d got %b exp %b", j, obs, exp_v);
      else pass_cnt++;
    end
  endtask

  initial begin
    rst        = 1'b1;
    sw_rst_req = 1'b0;
    test_reset();
    test_power_on();
    test_sw_reset();
    test_ignored();
    test_async_abort();
    test_saturation();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
